// File: rtl/wen_pkg.sv
// Shared constants and width helpers for the round-robin write-enable controller.
package wen_pkg;

  localparam int DEF_NCH    = 4;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_CNT_W  = 16;

  // Ceiling log2 for n >= 1 (returns 0 for n == 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Channel-index width; a single channel still needs one bit.
  function automatic int wsel_w(input int nch);
    return (nch > 1) ? clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/wen_rr_ctrl_arbiter.sv
// Combinational round-robin arbiter: finds the first requester at or after the
// search-start pointer, wrapping modulo NCH. The pointer register lives in the parent.
module rr_arbiter
  import wen_pkg::*;
#(
  parameter  int NCH    = DEF_NCH,
  localparam int WSEL_W = wsel_w(NCH)
) (
  input  logic [NCH-1:0]    req,
  input  logic              advance,
  input  logic [WSEL_W-1:0] ptr,
  output logic [NCH-1:0]    grant_nxt,
  output logic [WSEL_W-1:0] idx
);

  localparam logic [WSEL_W:0] NCH_L = (WSEL_W + 1)'(NCH);

  logic [NCH-1:0]    rot;
  logic [WSEL_W-1:0] off;
  logic [WSEL_W:0]   sum;

  // Rotate so the search-start channel lands at bit 0.
  assign rot = NCH'({req, req} >> ptr);

  // NOTE: every variable written in a combinational block gets a default at the
  // top, so no path can leave it unassigned and infer a latch.
  always_comb begin
    off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) off = WSEL_W'(i);
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= NCH_L) ? WSEL_W'(sum - NCH_L) : sum[WSEL_W-1:0];

  always_comb begin
    grant_nxt = '0;
    for (int j = 0; j < NCH; j++) begin
      grant_nxt[j] = advance && (|req) && (idx == WSEL_W'(j));
    end
  end

endmodule

// File: rtl/wen_rr_ctrl.sv
// Write-enable controller for the cpu-fifo write port: round-robin arbitration of
// NCH requesters, gated by global enable and FIFO occupancy, with a stall counter.
module wen_rr_ctrl
  import wen_pkg::*;
#(
  parameter  int NCH    = DEF_NCH,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int WSEL_W = wsel_w(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NCH-1:0]    req,
  input  logic              rd_en,
  input  logic              clr_stall,
  output logic [NCH-1:0]    grant,
  output logic              wen,
  output logic [WSEL_W-1:0] wsel,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [ADDR_W:0]  DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] STALL_MAX = '1;
  localparam logic [WSEL_W:0]  NCH_L     = (WSEL_W + 1)'(NCH);

  logic [WSEL_W-1:0] rr_ptr;
  logic [WSEL_W-1:0] arb_idx;
  logic [WSEL_W-1:0] ptr_nxt;
  logic [WSEL_W:0]   ptr_inc;
  logic [NCH-1:0]    arb_grant;
  logic [ADDR_W-1:0] wr_ptr;
  logic              issue;
  logic              rd_ok;
  logic              stall_hit;

  // Full is judged on the registered count, so a same-cycle read cannot make room.
  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign issue     = en && !full && (|req);
  assign rd_ok     = rd_en && !empty;
  assign stall_hit = (|req) && !issue;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req       (req),
    .advance   (issue),
    .ptr       (rr_ptr),
    .grant_nxt (arb_grant),
    .idx       (arb_idx)
  );

  // Next search starts just past the winner, wrapping at NCH.
  assign ptr_inc = {1'b0, arb_idx} + (WSEL_W + 1)'(1);
  assign ptr_nxt = (ptr_inc == NCH_L) ? '0 : ptr_inc[WSEL_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      wen   <= 1'b0;
      wsel  <= '0;
      waddr <= '0;
    end else begin
      grant <= arb_grant;
      wen   <= issue;
      if (issue) begin
        wsel  <= arb_idx;
        waddr <= wr_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rr_ptr <= '0;
    end else if (issue) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      rr_ptr <= ptr_nxt;
    end
  end

  // Write and read on the same edge cancel; reads of an empty FIFO are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({issue, rd_ok})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_stall) begin
      stall_cnt <= '0;
    end else if (stall_hit && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wen_rr_ctrl.sv
// Scoreboard bench for wen_rr_ctrl (NCH=4, ADDR_W=2, CNT_W=3): directed scenarios
// plus randomized traffic against a behavioural occupancy/round-robin model.
module tb_wen_rr_ctrl;

  localparam int NCH       = 4;
  localparam int ADDR_W    = 2;
  localparam int CNT_W     = 3;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [NCH-1:0]   req;
  logic             rd_en;
  logic             clr_stall;
  logic [NCH-1:0]   grant;
  logic             wen;
  logic [1:0]       wsel;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]  count;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] stall_cnt;

  wen_rr_ctrl #(.NCH(NCH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .rd_en     (rd_en),
    .clr_stall (clr_stall),
    .grant     (grant),
    .wen       (wen),
    .wsel      (wsel),
    .waddr     (waddr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic [1:0] wsel;
    logic [1:0] waddr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state.
  logic [NCH-1:0] pend;
  int m_cnt, m_wptr, m_start, m_stall, last_win;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a write is presented, and flags a write
  // that was due but never appeared.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wen === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_wen", 32'(wen), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("wen_cycle", cyc, mon_e.cyc);
          check("grant", 32'(grant), 32'(mon_e.grant));
          check("wsel", 32'(wsel), 32'(mon_e.wsel));
          check("waddr", 32'(waddr), 32'(mon_e.waddr));
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        check("missed_wen", 32'(wen), 32'd1);
      end
    end
  end

  task automatic model_reset();
    m_cnt = 0; m_wptr = 0; m_start = 0; m_stall = 0; last_win = -1;
    pend = '0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; rd_en = 1'b0; clr_stall = 1'b0; req = '0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, predict from the rules, advance, then check state.
  task automatic step(input logic e, input logic r, input logic c);
    int   win;
    int   k2;
    logic iss;
    logic rd;
    exp_t ne;
    en = e; rd_en = r; clr_stall = c; req = pend;
    iss = e && (m_cnt < DEPTH) && (pend != '0);
    win = -1;
    if (iss) begin
      for (int k = 0; k < NCH; k++) begin
        k2 = (m_start + k) % NCH;
        if (win < 0 && pend[2'(k2)]) win = k2;
      end
    end
    if (c) m_stall = 0;
    else if (pend != '0 && !(e && m_cnt < DEPTH) && m_stall < STALL_MAX) m_stall++;
    rd = r && (m_cnt > 0);
    if (iss) begin
      ne.cyc   = cyc + 1;
      ne.grant = 4'(1 << win);
      ne.wsel  = 2'(win);
      ne.waddr = 2'(m_wptr);
      sb.push_back(ne);
      m_wptr  = (m_wptr + 1) % DEPTH;
      m_start = (win + 1) % NCH;
    end
    m_cnt = m_cnt + (iss ? 1 : 0) - (rd ? 1 : 0);
    last_win = win;
    @(posedge clk); #1;
    if (iss) pend[2'(win)] = 1'b0;
    check("count", 32'(count), m_cnt);
    check("full", 32'(full), 32'(m_cnt == DEPTH));
    check("empty", 32'(empty), 32'(m_cnt == 0));
    check("stall_cnt", 32'(stall_cnt), m_stall);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; rd_en = 1'b0; clr_stall = 1'b0; req = '0;
    model_reset();
    #2;
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T2: all channels continuously requesting -> 0,1,2,3,0 with addresses wrapping.
    for (int k = 0; k < 5; k++) begin
      pend = 4'hF;
      step(1'b1, 1'b1, 1'b0);
      check("t2_grant", 32'(grant), 32'(1 << (k % NCH)));
      check("t2_waddr", 32'(waddr), 32'(k % DEPTH));
    end

    // T3: fill without reads; further requests stall.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      pend = 4'hF;
      step(1'b1, 1'b0, 1'b0);
    end
    check("t3_full", 32'(full), 32'd1);
    check("t3_count", 32'(count), 32'd4);
    check("t3_no_wen", 32'(wen), 32'd0);
    check("t3_stall", 32'(stall_cnt), 32'd2);

    // T4: write and read on the same edge at count 2, then read while empty.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      pend = 4'b0101;
      step(1'b1, 1'b0, 1'b0);
    end
    pend = 4'b0010;
    step(1'b1, 1'b1, 1'b0);
    check("t4_same_edge", 32'(count), 32'd2);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t4_underflow", 32'(count), 32'd0);
    check("t4_empty", 32'(empty), 32'd1);

    // T5: six writes interleaved with reads -> address wrap without filling.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      pend = 4'(1 << $urandom_range(0, NCH - 1));
      step(1'b1, 1'b1, 1'b0);
      check("t5_waddr", 32'(waddr), 32'(k % DEPTH));
      check("t5_not_full", 32'(full), 32'd0);
    end

    // T6: enable low with a pending request saturates the stall counter; clear wins.
    do_reset();
    pend = 4'b0001;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);
    check("t6_saturate", 32'(stall_cnt), 32'(STALL_MAX));
    check("t6_no_wen", 32'(wen), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("t6_clear", 32'(stall_cnt), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("t6_grant0", 32'(grant), 32'd1);

    // T1: asynchronous reset in the middle of traffic with a write in flight.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pend = 4'hF;
      step(1'b1, 1'b0, 1'b0);
    end
    check("t1_pre_wen", 32'(wen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_grant", 32'(grant), 32'd0);
    check("t1_wen", 32'(wen), 32'd0);
    check("t1_wsel", 32'(wsel), 32'd0);
    check("t1_waddr", 32'(waddr), 32'd0);
    check("t1_count", 32'(count), 32'd0);
    check("t1_stall", 32'(stall_cnt), 32'd0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0);
      check("t1_idle_wen", 32'(wen), 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) != 0) pend = pend | 4'($urandom_range(0, 15));
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
    end

    // Drain: every predicted write must have been observed.
    pend = '0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
